// File: rtl/mem_access_stage_if.sv
// ============================================================================
//  Module  : mem_access_stage_if
//  Purpose : data-memory req/gnt/rvalid bus between the MEM stage and memory
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
//  Module  : mem_access_stage
//  Purpose : MEM pipeline stage; runs loads/stores over req/gnt/rvalid bus
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int unsigned TIMEOUT = 64
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [31:0]     alu_out_i,
  input  wire logic [31:0]     rs2_data_i,
  input  wire logic [6:0]      opcode_i,
  input  wire logic [2:0]      funct3_i,
  input  wire logic [6:0]      funct7_i,
  input  wire logic [4:0]      rd_i,
  output logic                 stall_o,
  mem_access_stage_if.master   dmem,
  output logic [31:0]          alu_out_o,
  output logic [6:0]           opcode_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [4:0]           rd_o,
  output logic [31:0]          load_out_o,
  output logic                 misalign_o,
  output logic                 bus_err_o
);

  localparam logic [6:0] c_OP_LOAD    = 7'b0000011;
  localparam logic [6:0] c_OP_STORE   = 7'b0100011;
  localparam logic [6:0] c_OPCODE_NOP = 7'b0010011;
  localparam logic [2:0] c_FUNCT3_NOP = 3'b000;
  localparam logic [6:0] c_FUNCT7_NOP = 7'b0000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_rs2, r_cnt;
  logic [6:0]  r_opcode, r_funct7;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;

  logic        w_is_mem, w_misalign, w_timeout;
  logic [1:0]  w_a;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt, w_wdata;
  logic [3:0]  w_be;

  assign w_is_mem   = (opcode_i == c_OP_LOAD) || (opcode_i == c_OP_STORE);
  assign w_misalign = ((funct3_i[1:0] == 2'b01) && alu_out_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (alu_out_i[1:0] != 2'b00));
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 1);

  assign w_a    = r_addr[1:0];
  assign w_byte = dmem.dmem_rdata[{w_a, 3'b000} +: 8];
  assign w_half = w_a[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_fmt = {24'd0, w_byte};
      3'b101:  w_load_fmt = {16'd0, w_half};
      default: w_load_fmt = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_rs2;
    if (r_opcode == c_OP_STORE) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{r_rs2[7:0]}};
        end
        2'b01: begin
          w_be    = w_a[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{r_rs2[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Bus side is gated by rst_n so an asynchronous reset silences it immediately.
  assign dmem.dmem_addr  = rst_n ? {r_addr[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_be    = rst_n ? w_be : 4'd0;
  assign dmem.dmem_wdata = rst_n ? w_wdata : 32'd0;
  assign dmem.dmem_we    = rst_n && (r_opcode == c_OP_STORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 32'd0;
      r_addr   <= 32'd0;
      r_rs2    <= 32'd0;
      r_opcode <= 7'd0;
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
      r_rd     <= 5'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_RESP && w_next == S_RESP) ? r_cnt + 32'd1 : 32'd0;
      if (r_state == S_IDLE && w_is_mem) begin
        r_addr   <= alu_out_i;
        r_rs2    <= rs2_data_i;
        r_opcode <= opcode_i;
        r_funct3 <= funct3_i;
        r_funct7 <= funct7_i;
        r_rd     <= rd_i;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    stall_o       = 1'b0;
    dmem.dmem_req = 1'b0;
    misalign_o    = 1'b0;
    bus_err_o     = 1'b0;
    alu_out_o     = 32'd0;
    opcode_o      = c_OPCODE_NOP;
    funct3_o      = c_FUNCT3_NOP;
    funct7_o      = c_FUNCT7_NOP;
    rd_o          = 5'd0;
    load_out_o    = 32'd0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (!w_is_mem || w_misalign) begin
            alu_out_o  = alu_out_i;
            opcode_o   = opcode_i;
            funct3_o   = funct3_i;
            funct7_o   = funct7_i;
            rd_o       = w_is_mem ? 5'd0 : rd_i;
            misalign_o = w_is_mem;
          end else begin
            stall_o = 1'b1;
            w_next  = S_REQ;
          end
        end
        S_REQ: begin
          dmem.dmem_req = 1'b1;
          stall_o       = 1'b1;
          if (dmem.dmem_gnt) w_next = S_RESP;
        end
        S_RESP: begin
          if (dmem.dmem_rvalid || w_timeout) begin
            alu_out_o  = r_addr;
            opcode_o   = r_opcode;
            funct3_o   = r_funct3;
            funct7_o   = r_funct7;
            w_next     = S_IDLE;
            if (dmem.dmem_rvalid) begin
              rd_o       = r_rd;
              load_out_o = (r_opcode == c_OP_LOAD) ? w_load_fmt : 32'd0;
            end else begin
              bus_err_o = 1'b1;
            end
          end else begin
            stall_o = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
//  Module  : tb_mem_access_stage
//  Purpose : self-checking bench for mem_access_stage against a behavioural model
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
  localparam int unsigned TO = 64;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_NOP   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_out_i, rs2_data_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        stall_o, misalign_o, bus_err_o;
  logic [31:0] alu_out_o, load_out_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_out_i  (alu_out_i),
    .rs2_data_i (rs2_data_i),
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .funct7_i   (funct7_i),
    .rd_i       (rd_i),
    .stall_o    (stall_o),
    .dmem       (bus),
    .alu_out_o  (alu_out_o),
    .opcode_o   (opcode_o),
    .funct3_o   (funct3_o),
    .funct7_o   (funct7_o),
    .rd_o       (rd_o),
    .load_out_o (load_out_o),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * int'(a))) & 32'hFF;
    h = (d >> ((a >= 2'd2) ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_be(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [1:0] a);
    if (op != OP_STORE || f3 == 3'd2) return 32'hF;
    if (f3 == 3'd0) return 32'd1 << a;
    return (a >= 2'd2) ? 32'hC : 32'h3;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One instruction from first presentation to retirement; gnt_dly = REQ cycles
  // before gnt, rv_dly = RESP cycles before rvalid (-1 = never, forces timeout).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rs2,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           output int stalls);
    bit is_ld, is_mem, mis, done;
    int cyc, r;
    logic [1:0] a;
    a      = addr[1:0];
    is_ld  = (op == OP_LOAD);
    is_mem = is_ld || (op == OP_STORE);
    mis    = is_mem && ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a != 2'd0));
    stalls = 0; done = 0; cyc = 0;
    alu_out_i = addr; rs2_data_i = rs2; opcode_i = op; funct3_i = f3; funct7_i = f7; rd_i = rd;
    while (!done && cyc < 200) begin
      r = cyc - 2 - gnt_dly;
      bus.dmem_gnt = is_mem && !mis && (cyc == 1 + gnt_dly);
      if (is_mem && !mis && r >= 0) begin
        bus.dmem_rvalid = (r == rv_dly);
        bus.dmem_rdata  = rdata;
      end else begin
        bus.dmem_rvalid = 1'($urandom_range(0, 1));
        bus.dmem_rdata  = $urandom;
      end
      #2;
      if (!is_mem || mis) begin
        check_eq("pass_stall", stall_o, 0);
        check_eq("pass_req", bus.dmem_req, 0);
        check_eq("pass_opcode", opcode_o, op);
        check_eq("pass_alu", alu_out_o, addr);
        check_eq("pass_f3f7", {funct3_o, funct7_o}, {f3, f7});
        check_eq("pass_rd", rd_o, mis ? 5'd0 : rd);
        check_eq("pass_load", load_out_o, 0);
        check_eq("pass_misalign", misalign_o, mis);
        check_eq("pass_buserr", bus_err_o, 0);
        done = 1;
      end else if (cyc == 0) begin
        check_eq("acc_stall", stall_o, 1);
        check_eq("acc_req", bus.dmem_req, 0);
        check_eq("acc_nop", {opcode_o, rd_o, misalign_o}, {OP_NOP, 5'd0, 1'b0});
      end else if (r < 0) begin
        check_eq("req_req", bus.dmem_req, 1);
        check_eq("req_stall", stall_o, 1);
        check_eq("req_we", bus.dmem_we, op == OP_STORE);
        check_eq("req_addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
        check_eq("req_be", bus.dmem_be, exp_be(op, f3, a));
        if (op == OP_STORE) check_eq("req_wdata", bus.dmem_wdata, exp_wdata(f3, rs2));
        check_eq("req_nop", opcode_o, OP_NOP);
      end else if (r == rv_dly) begin
        check_eq("ret_req", bus.dmem_req, 0);
        check_eq("ret_stall", stall_o, 0);
        check_eq("ret_fields", {opcode_o, funct3_o, funct7_o, rd_o}, {op, f3, f7, rd});
        check_eq("ret_alu", alu_out_o, addr);
        check_eq("ret_load", load_out_o, is_ld ? exp_load(f3, a, rdata) : 32'd0);
        check_eq("ret_buserr", bus_err_o, 0);
        done = 1;
      end else if (r == int'(TO) - 1) begin
        check_eq("to_buserr", bus_err_o, 1);
        check_eq("to_stall", stall_o, 0);
        check_eq("to_rd_load", {rd_o, load_out_o}, 37'd0);
        check_eq("to_opcode", opcode_o, op);
        done = 1;
      end else begin
        check_eq("resp_req", bus.dmem_req, 0);
        check_eq("resp_stall", stall_o, 1);
        check_eq("resp_buserr", bus_err_o, 0);
        check_eq("resp_nop", opcode_o, OP_NOP);
      end
      stalls += int'(stall_o);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_eq("retired", done, 1);
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
  endtask

  initial begin
    int st;
    int k, gd, rv;
    logic [2:0] f3;
    logic [6:0] op;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
    alu_out_i = 32'h1234_5678; rs2_data_i = 32'h1; opcode_i = OP_ADD;
    funct3_i = 3'd3; funct7_i = 7'h20; rd_i = 5'd7;
    #2;
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_req", bus.dmem_req, 0);
    check_eq("rst_nop", {opcode_o, funct3_o, funct7_o}, {OP_NOP, 3'd0, 7'd0});
    check_eq("rst_alu_rd", {alu_out_o, rd_o}, 37'd0);
    check_eq("rst_be", bus.dmem_be, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_instr(OP_LOAD, 3'd2, 7'd0, 5'd1, 32'h100, 32'd0, 0, 1, 32'hDEADBEEF, st);
    check_eq("lw_stalls", st, 3);
    run_instr(OP_LOAD, 3'd0, 7'd0, 5'd2, 32'h103, 32'd0, 0, 0, 32'h80112233, st);
    run_instr(OP_LOAD, 3'd4, 7'd0, 5'd3, 32'h103, 32'd0, 1, 2, 32'h80112233, st);
    run_instr(OP_LOAD, 3'd1, 7'd0, 5'd4, 32'h102, 32'd0, 0, 0, 32'h80112233, st);
    run_instr(OP_STORE, 3'd0, 7'd0, 5'd0, 32'h201, 32'h000000A5, 0, 0, 32'h0, st);
    run_instr(OP_STORE, 3'd1, 7'd0, 5'd0, 32'h202, 32'h0000BEEF, 0, 1, 32'h0, st);
    run_instr(OP_LOAD, 3'd2, 7'd0, 5'd5, 32'h102, 32'd0, 0, 0, 32'h0, st);
    run_instr(OP_LOAD, 3'd2, 7'd0, 5'd6, 32'h3C0, 32'd0, 5, 0, 32'h0BADF00D, st);
    run_instr(OP_LOAD, 3'd2, 7'd0, 5'd7, 32'h400, 32'd0, 0, -1, 32'h0, st);
    run_instr(OP_ADD, 3'd0, 7'h20, 5'd8, 32'h55, 32'd0, 0, 0, 32'h0, st);

    // Asynchronous reset while a load waits in RESP.
    alu_out_i = 32'h500; opcode_i = OP_LOAD; funct3_i = 3'd2; rd_i = 5'd9;
    @(negedge clk);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_req", bus.dmem_req, 0);
    check_eq("arst_stall", stall_o, 0);
    check_eq("arst_nop", {opcode_o, funct3_o, funct7_o, rd_o}, {OP_NOP, 3'd0, 7'd0, 5'd0});
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(OP_ADD, 3'd0, 7'd0, 5'd10, 32'h77, 32'd0, 0, 0, 32'h0, st);
    check_eq("arst_add_stalls", st, 0);

    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0:       begin op = OP_LOAD;  f3 = ld_f3[$urandom_range(0, 4)]; end
        1:       begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
        2:       begin op = OP_ADD;   f3 = 3'($urandom); end
        default: begin op = OP_NOP;   f3 = 3'($urandom); end
      endcase
      gd = $urandom_range(0, 4);
      rv = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 3);
      run_instr(op, f3, 7'($urandom), 5'($urandom), $urandom, $urandom, gd, rv, $urandom, st);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
